// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift_reg serial link blocks: FSM state encodings
// and the bit-counter width helper reused by the PISO and SIPO variants.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    // A counter that must hold values up to w (frame length minus one with parity).
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Loadable down-counter for the PISO transmitter; saturates at zero and flags it.
module piso_bit_cnt #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    assign zero = (count == '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/shift_reg_piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready input and registered serial output.
// Optional even-parity bit after the data bits when SHIFT_REG_PISO_PARITY_EN is defined.
module shift_reg_piso_tx
    import shift_reg_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             done
);

`ifdef SHIFT_REG_PISO_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif
    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic             sdo_nxt, sdo_valid_nxt, done_nxt;
    logic             accept;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt;
`ifdef SHIFT_REG_PISO_PARITY_EN
    logic             par, par_nxt;
`endif

    piso_bit_cnt #(.CNT_W(CNT_W)) u_bit_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (CNT_W'(FLEN - 1)),
        .dec      (cnt_dec),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    // Ready in IDLE and on the last frame bit, so back-to-back words leave no gap.
    assign din_ready = !reset && ((state == ST_IDLE) || cnt_zero);
    assign accept    = din_valid && din_ready;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        sdo_nxt       = 1'b0;
        sdo_valid_nxt = 1'b0;
        done_nxt      = 1'b0;
        cnt_load      = 1'b0;
        cnt_dec       = 1'b0;
`ifdef SHIFT_REG_PISO_PARITY_EN
        par_nxt       = par;
`endif
        if (accept) begin
            state_nxt     = ST_SHIFT;
            sdo_nxt       = (MSB_FIRST != 0) ? din[WIDTH-1] : din[0];
            shreg_nxt     = (MSB_FIRST != 0) ? (din << 1) : (din >> 1);
            sdo_valid_nxt = 1'b1;
            cnt_load      = 1'b1;
`ifdef SHIFT_REG_PISO_PARITY_EN
            par_nxt       = ^din;
`endif
        end else begin
            case (state)
                ST_SHIFT: begin
                    if (!cnt_zero) begin
                        sdo_valid_nxt = 1'b1;
                        cnt_dec       = 1'b1;
                        done_nxt      = (cnt == CNT_W'(1));
`ifdef SHIFT_REG_PISO_PARITY_EN
                        if (cnt == CNT_W'(1)) begin
                            state_nxt = ST_PARITY;
                            sdo_nxt   = par;
                        end else
`endif
                        begin
                            sdo_nxt   = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
                            shreg_nxt = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
                        end
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            sdo       <= 1'b0;
            sdo_valid <= 1'b0;
            done      <= 1'b0;
`ifdef SHIFT_REG_PISO_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            sdo       <= sdo_nxt;
            sdo_valid <= sdo_valid_nxt;
            done      <= done_nxt;
`ifdef SHIFT_REG_PISO_PARITY_EN
            par       <= par_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_shift_reg_piso_tx.sv
// Self-checking bench for shift_reg_piso_tx: MSB-first and LSB-first instances
// checked every cycle against a queue-of-frame-bits reference model.
module tb_shift_reg_piso_tx;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             rdy_m, sdo_m, val_m, done_m;
    logic             rdy_l, sdo_l, val_l, done_l;

    int checks   = 0;
    int failures = 0;

    // Expected serial bits still to appear, front = bit on sdo this cycle.
    bit q_msb[$];
    bit q_lsb[$];

    always #5 clk = ~clk;

    shift_reg_piso_tx #(.WIDTH(WIDTH), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(rdy_m), .sdo(sdo_m), .sdo_valid(val_m), .done(done_m)
    );

    shift_reg_piso_tx #(.WIDTH(WIDTH), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(rdy_l), .sdo(sdo_l), .sdo_valid(val_l), .done(done_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit frame_parity(input logic [WIDTH-1:0] w);
        bit p = 1'b0;
        for (int i = 0; i < WIDTH; i++) p ^= w[i];
        return p;
    endfunction

    // One clock cycle: drive inputs, compare all outputs with the model, advance the model.
    task automatic cycle(input logic rst, input logic v, input logic [WIDTH-1:0] d);
        bit exp_rdy;
        @(negedge clk);
        reset = rst; din_valid = v; din = d;
        #1;
        exp_rdy = !rst && (q_msb.size() <= 1);
        check("ready_msb", {31'd0, rdy_m}, {31'd0, exp_rdy});
        check("ready_lsb", {31'd0, rdy_l}, {31'd0, exp_rdy});
        check("sdo_msb",   {31'd0, sdo_m},  {31'd0, (q_msb.size() > 0) ? q_msb[0] : 1'b0});
        check("valid_msb", {31'd0, val_m},  {31'd0, q_msb.size() > 0});
        check("done_msb",  {31'd0, done_m}, {31'd0, q_msb.size() == 1});
        check("sdo_lsb",   {31'd0, sdo_l},  {31'd0, (q_lsb.size() > 0) ? q_lsb[0] : 1'b0});
        check("valid_lsb", {31'd0, val_l},  {31'd0, q_lsb.size() > 0});
        check("done_lsb",  {31'd0, done_l}, {31'd0, q_lsb.size() == 1});
        if (rst) begin
            q_msb.delete();
            q_lsb.delete();
        end else begin
            if (q_msb.size() > 0) void'(q_msb.pop_front());
            if (q_lsb.size() > 0) void'(q_lsb.pop_front());
            if (v && exp_rdy) begin
                for (int i = WIDTH - 1; i >= 0; i--) q_msb.push_back(d[i]);
                for (int i = 0; i < WIDTH; i++) q_lsb.push_back(d[i]);
`ifdef SHIFT_REG_PISO_PARITY_EN
                q_msb.push_back(frame_parity(d));
                q_lsb.push_back(frame_parity(d));
`endif
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0);
    endtask

    initial begin
        reset = 1'b1; din_valid = 1'b0; din = '0;
        repeat (2) @(posedge clk);

        // Reset held with din_valid high: nothing accepted.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 4'hF);
        idle(2);

        // Single words, MSB and LSB instances see the same stimulus.
        cycle(1'b0, 1'b1, 4'b1011);
        idle(7);
        cycle(1'b0, 1'b1, 4'b1000);
        idle(7);

        // Back-to-back with din_valid held high.
        cycle(1'b0, 1'b1, 4'hA);
        while (q_msb.size() > 1) cycle(1'b0, 1'b1, 4'hA);
        cycle(1'b0, 1'b1, 4'h5);
        idle(7);

        // Mid-frame reset after two bits of 4'hF, then a clean word.
        cycle(1'b0, 1'b1, 4'hF);
        idle(2);
        cycle(1'b1, 1'b0, '0);
        idle(2);
        cycle(1'b0, 1'b1, 4'h3);
        idle(7);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                  WIDTH'($urandom));
        end
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
